game_control: RTL and testbench

- Top-level game-state and physics controller for a two-car racing game.
- Holds the IDLE/RACE/FINISH state machine and the per-car speed, heading and position registers.
- Advances physics once per render frame; each frame is marked by a rising edge of a slow render strobe.
- Its outputs feed the renderer and the SRAM/track logic.

---
 rtl/game_pkg.sv | 52 +++++
 rtl/track_pkg.sv | 11 +
 rtl/car_physics.sv | 72 +++++++
 rtl/game_control.sv | 124 ++++++++++++
 tb/tb_game_control.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game types: FSM states, per-car state record, winner codes and the
// 16-direction cosine table used by the physics update.
package game_pkg;

  localparam int POS_W     = 10;
  localparam int SPD_W     = 4;
  localparam int MAX_SPEED = 15;
  localparam int FRICTION  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RACE   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [SPD_W-1:0] speed;
    logic [3:0]       heading;
  } car_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_CAR1 = 2'd1;
  localparam logic [1:0] WIN_CAR2 = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  // cos(heading * 22.5 deg) scaled by 8; heading 0 points along +x
  function automatic logic signed [4:0] cos_lut(input logic [3:0] idx);
    logic signed [4:0] c;
    case (idx)
      4'd0:    c = 5'sd8;
      4'd1:    c = 5'sd7;
      4'd2:    c = 5'sd6;
      4'd3:    c = 5'sd3;
      4'd4:    c = 5'sd0;
      4'd5:    c = -5'sd3;
      4'd6:    c = -5'sd6;
      4'd7:    c = -5'sd7;
      4'd8:    c = -5'sd8;
      4'd9:    c = -5'sd7;
      4'd10:   c = -5'sd6;
      4'd11:   c = -5'sd3;
      4'd12:   c = 5'sd0;
      4'd13:   c = 5'sd3;
      4'd14:   c = 5'sd6;
      default: c = 5'sd7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/track_pkg.sv
// Track geometry: position clamp, finish line and car start positions.
package track_pkg;

  localparam int POS_MAX  = 1023;
  localparam int FINISH_X = 600;
  localparam int CAR1_X0  = 40;
  localparam int CAR1_Y0  = 200;
  localparam int CAR2_X0  = 40;
  localparam int CAR2_Y0  = 240;

endpackage

// File: rtl/car_physics.sv
// Combinational one-frame physics step for a single car; passes the car
// through unchanged when not enabled.
module car_physics
  import game_pkg::*;
  import track_pkg::*;
(
  input  car_t       car_i,
  input  logic [2:0] acc_i,
  input  logic [1:0] omega_i,
  input  logic       enable_i,
  output car_t       car_o
);

  logic signed [5:0]  spd_sum;
  logic [SPD_W-1:0]   speed_n;
  logic [3:0]         heading_n;
  logic signed [15:0] spd_ext;
  logic signed [15:0] cos_ext;
  logic signed [15:0] sin_ext;
  logic signed [15:0] dx;
  logic signed [15:0] dy;
  logic signed [16:0] x_sum;
  logic signed [16:0] y_sum;

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [16:0] v);
    logic [POS_W-1:0] r;
    if (v < 17'sd0)
      r = '0;
    else if (v > $signed(17'(POS_MAX)))
      r = POS_W'(POS_MAX);
    else
      r = v[POS_W-1:0];
    return r;
  endfunction

  always_comb begin
    spd_sum = $signed({2'b00, car_i.speed}) + $signed({3'b000, acc_i});
    if (acc_i == 3'd0)
      spd_sum = spd_sum - $signed(6'(FRICTION));

    if (spd_sum < 6'sd0)
      speed_n = '0;
    else if (spd_sum > $signed(6'(MAX_SPEED)))
      speed_n = SPD_W'(MAX_SPEED);
    else
      speed_n = spd_sum[SPD_W-1:0];

    case (omega_i)
      2'b01:   heading_n = car_i.heading + 4'd1;
      2'b10:   heading_n = car_i.heading - 4'd1;
      default: heading_n = car_i.heading;
    endcase

    // displacement uses the pre-update speed and heading
    spd_ext = $signed({12'b0, car_i.speed});
    cos_ext = cos_lut(car_i.heading);
    sin_ext = cos_lut(car_i.heading - 4'd4);
    dx      = (spd_ext * cos_ext) >>> 3;
    dy      = (spd_ext * sin_ext) >>> 3;
    x_sum   = $signed({7'b0, car_i.x}) + dx;
    y_sum   = $signed({7'b0, car_i.y}) + dy;

    car_o = car_i;
    if (enable_i) begin
      car_o.speed   = speed_n;
      car_o.heading = heading_n;
      car_o.x       = clamp_pos(x_sum);
      car_o.y       = clamp_pos(y_sum);
    end
  end

endmodule

// File: rtl/game_control.sv
// Game FSM (IDLE/RACE/FINISH) and per-car state registers, advanced once per
// synchronized rising edge of the render strobe.
module game_control
  import game_pkg::*;
  import track_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_render_clk,
  input  logic             i_next_state,
  input  logic [2:0]       i_car1_acc,
  input  logic [2:0]       i_car2_acc,
  input  logic [1:0]       i_car1_omega,
  input  logic [1:0]       i_car2_omega,
  output logic [1:0]       o_state,
  output logic             o_frame_tick,
  output logic [POS_W-1:0] o_car1_x,
  output logic [POS_W-1:0] o_car1_y,
  output logic [POS_W-1:0] o_car2_x,
  output logic [POS_W-1:0] o_car2_y,
  output logic [SPD_W-1:0] o_car1_speed,
  output logic [SPD_W-1:0] o_car2_speed,
  output logic [3:0]       o_car1_heading,
  output logic [3:0]       o_car2_heading,
  output logic [1:0]       o_winner
);

  localparam car_t CAR1_RST = '{x: POS_W'(CAR1_X0), y: POS_W'(CAR1_Y0),
                                speed: '0, heading: '0};
  localparam car_t CAR2_RST = '{x: POS_W'(CAR2_X0), y: POS_W'(CAR2_Y0),
                                speed: '0, heading: '0};

  logic   render_s1_q, render_s2_q, render_s3_q;
  logic   tick;
  logic   tick_q;
  state_e state_q;
  logic [1:0] winner_q;
  car_t   car1_q, car2_q;
  car_t   car1_d, car2_d;
  logic   race_en;
  logic   car1_fin, car2_fin;

  assign tick     = render_s2_q & ~render_s3_q;
  assign race_en  = (state_q == ST_RACE);
  assign car1_fin = (car1_d.x >= POS_W'(FINISH_X));
  assign car2_fin = (car2_d.x >= POS_W'(FINISH_X));

  car_physics u_car1 (
    .car_i    (car1_q),
    .acc_i    (i_car1_acc),
    .omega_i  (i_car1_omega),
    .enable_i (race_en),
    .car_o    (car1_d)
  );

  car_physics u_car2 (
    .car_i    (car2_q),
    .acc_i    (i_car2_acc),
    .omega_i  (i_car2_omega),
    .enable_i (race_en),
    .car_o    (car2_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      render_s1_q <= 1'b0;
      render_s2_q <= 1'b0;
      render_s3_q <= 1'b0;
      tick_q      <= 1'b0;
      state_q     <= ST_IDLE;
      winner_q    <= WIN_NONE;
      car1_q      <= CAR1_RST;
      car2_q      <= CAR2_RST;
    end else begin
      render_s1_q <= i_render_clk;
      render_s2_q <= render_s1_q;
      render_s3_q <= render_s2_q;
      tick_q      <= tick;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            car1_q <= CAR1_RST;
            car2_q <= CAR2_RST;
            if (i_next_state) begin
              state_q  <= ST_RACE;
              winner_q <= WIN_NONE;
            end
          end
          ST_RACE: begin
            car1_q <= car1_d;
            car2_q <= car2_d;
            // winner code bits line up with {car2, car1} crossing
            if (car1_fin || car2_fin) begin
              state_q  <= ST_FINISH;
              winner_q <= {car2_fin, car1_fin};
            end
          end
          ST_FINISH: begin
            if (i_next_state) begin
              state_q  <= ST_IDLE;
              winner_q <= WIN_NONE;
              car1_q   <= CAR1_RST;
              car2_q   <= CAR2_RST;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_state        = state_q;
  assign o_frame_tick   = tick_q;
  assign o_winner       = winner_q;
  assign o_car1_x       = car1_q.x;
  assign o_car1_y       = car1_q.y;
  assign o_car2_x       = car2_q.x;
  assign o_car2_y       = car2_q.y;
  assign o_car1_speed   = car1_q.speed;
  assign o_car2_speed   = car2_q.speed;
  assign o_car1_heading = car1_q.heading;
  assign o_car2_heading = car2_q.heading;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: vector table for the first race frames,
// then hand-written sequences for finish, tie, heading wrap and mid-race reset.
module tb_game_control;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_render_clk;
  logic       i_next_state;
  logic [2:0] i_car1_acc, i_car2_acc;
  logic [1:0] i_car1_omega, i_car2_omega;
  logic [1:0] o_state;
  logic       o_frame_tick;
  logic [9:0] o_car1_x, o_car1_y, o_car2_x, o_car2_y;
  logic [3:0] o_car1_speed, o_car2_speed;
  logic [3:0] o_car1_heading, o_car2_heading;
  logic [1:0] o_winner;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  game_control dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_render_clk   (i_render_clk),
    .i_next_state   (i_next_state),
    .i_car1_acc     (i_car1_acc),
    .i_car2_acc     (i_car2_acc),
    .i_car1_omega   (i_car1_omega),
    .i_car2_omega   (i_car2_omega),
    .o_state        (o_state),
    .o_frame_tick   (o_frame_tick),
    .o_car1_x       (o_car1_x),
    .o_car1_y       (o_car1_y),
    .o_car2_x       (o_car2_x),
    .o_car2_y       (o_car2_y),
    .o_car1_speed   (o_car1_speed),
    .o_car2_speed   (o_car2_speed),
    .o_car1_heading (o_car1_heading),
    .o_car2_heading (o_car2_heading),
    .o_winner       (o_winner)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // one render frame: tick must appear exactly on the 3rd clock after the edge
  task automatic do_frame();
    @(negedge i_clk) i_render_clk = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1 chk("tick_early", int'(o_frame_tick), 0);
    @(posedge i_clk);
    #1 chk("tick_on", int'(o_frame_tick), 1);
    @(negedge i_clk) i_render_clk = 1'b0;
    @(posedge i_clk);
    #1 chk("tick_pulse", int'(o_frame_tick), 0);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic nxt;
    int   a1, a2;
    int   st, s1, x1, s2, x2;
  } vec_t;

  vec_t vt[6];
  int c1s, c1x, c2x;

  initial begin
    vt[0] = '{1'b1, 0, 0, 1,  0, 40,  0, 40};
    vt[1] = '{1'b0, 7, 4, 1,  7, 40,  4, 40};
    vt[2] = '{1'b0, 7, 4, 1, 14, 47,  8, 44};
    vt[3] = '{1'b0, 7, 4, 1, 15, 61, 12, 52};
    vt[4] = '{1'b0, 0, 4, 1, 14, 76, 15, 64};
    vt[5] = '{1'b0, 0, 4, 1, 13, 90, 15, 79};

    i_rst_n = 1'b0; i_render_clk = 1'b0; i_next_state = 1'b0;
    i_car1_acc = '0; i_car2_acc = '0; i_car1_omega = '0; i_car2_omega = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_state", int'(o_state), 0);
    chk("rst_c1x", int'(o_car1_x), 40);
    chk("rst_c1y", int'(o_car1_y), 200);
    chk("rst_c2x", int'(o_car2_x), 40);
    chk("rst_c2y", int'(o_car2_y), 240);
    chk("rst_s1", int'(o_car1_speed), 0);
    chk("rst_s2", int'(o_car2_speed), 0);
    chk("rst_win", int'(o_winner), 0);
    chk("rst_tick", int'(o_frame_tick), 0);
    @(negedge i_clk) i_rst_n = 1'b1;

    // race A: car2 accelerates straight, car1 accelerates then coasts
    for (int i = 0; i < 6; i++) begin
      i_next_state = vt[i].nxt;
      i_car1_acc = 3'(vt[i].a1);
      i_car2_acc = 3'(vt[i].a2);
      do_frame();
      chk($sformatf("v%0d_state", i), int'(o_state), vt[i].st);
      chk($sformatf("v%0d_s1", i), int'(o_car1_speed), vt[i].s1);
      chk($sformatf("v%0d_x1", i), int'(o_car1_x), vt[i].x1);
      chk($sformatf("v%0d_s2", i), int'(o_car2_speed), vt[i].s2);
      chk($sformatf("v%0d_x2", i), int'(o_car2_x), vt[i].x2);
    end
    i_next_state = 1'b0;

    c1s = 13; c1x = 90;
    for (int f = 6; f <= 40; f++) begin
      i_car1_acc = 3'd0; i_car2_acc = 3'd4;
      do_frame();
      c1x = c1x + c1s;
      c1s = (c1s > 0) ? c1s - 1 : 0;
      c2x = 79 + 15 * (f - 5);
      chk($sformatf("a%0d_state", f), int'(o_state), (f == 40) ? 2 : 1);
      chk($sformatf("a%0d_s1", f), int'(o_car1_speed), c1s);
      chk($sformatf("a%0d_x1", f), int'(o_car1_x), c1x);
      chk($sformatf("a%0d_s2", f), int'(o_car2_speed), 15);
      chk($sformatf("a%0d_x2", f), int'(o_car2_x), c2x);
    end
    chk("a_winner", int'(o_winner), 2);
    chk("a_c2y", int'(o_car2_y), 240);
    chk("a_c1y", int'(o_car1_y), 200);

    for (int k = 0; k < 2; k++) begin
      do_frame();
      chk("frz_state", int'(o_state), 2);
      chk("frz_x2", int'(o_car2_x), 604);
      chk("frz_x1", int'(o_car1_x), 181);
      chk("frz_win", int'(o_winner), 2);
    end

    i_next_state = 1'b1;
    do_frame();
    chk("idle_state", int'(o_state), 0);
    chk("idle_c1x", int'(o_car1_x), 40);
    chk("idle_c2x", int'(o_car2_x), 40);
    chk("idle_s2", int'(o_car2_speed), 0);

    // race B: identical cars cross together
    do_frame();
    chk("b_enter", int'(o_state), 1);
    i_next_state = 1'b0;
    i_car1_acc = 3'd4; i_car2_acc = 3'd4;
    for (int f = 1; f <= 40; f++) begin
      do_frame();
      chk($sformatf("b%0d_state", f), int'(o_state), (f == 40) ? 2 : 1);
    end
    chk("b_winner", int'(o_winner), 3);
    chk("b_x1", int'(o_car1_x), 604);
    chk("b_x2", int'(o_car2_x), 604);
    i_next_state = 1'b1;
    do_frame();
    chk("b_idle", int'(o_state), 0);
    chk("b_idle_x1", int'(o_car1_x), 40);
    chk("b_idle_y2", int'(o_car2_y), 240);

    // race C: parked cars steering in opposite directions
    i_car1_acc = 3'd0; i_car2_acc = 3'd0;
    do_frame();
    chk("c_enter", int'(o_state), 1);
    i_next_state = 1'b0;
    i_car1_omega = 2'b10; i_car2_omega = 2'b01;
    for (int f = 1; f <= 17; f++) begin
      do_frame();
      chk($sformatf("c%0d_h2", f), int'(o_car2_heading), f % 16);
      chk($sformatf("c%0d_h1", f), int'(o_car1_heading), (16 - (f % 16)) % 16);
      chk($sformatf("c%0d_s2", f), int'(o_car2_speed), 0);
      chk($sformatf("c%0d_x2", f), int'(o_car2_x), 40);
    end

    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mrst_state", int'(o_state), 0);
    chk("mrst_h1", int'(o_car1_heading), 0);
    chk("mrst_h2", int'(o_car2_heading), 0);
    chk("mrst_c1y", int'(o_car1_y), 200);
    @(negedge i_clk) i_rst_n = 1'b1;
    do_frame();
    chk("post_rst_state", int'(o_state), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
